// File: rtl/square_freq_detector.sv
// Measures samples between hysteretic rising zero-crossings and derives floor(2^32/period) with a serial divider.
// Result appears 35 clocks after the edge step; no backpressure, an edge during a division parks in a last-wins pending slot.
module square_freq_detector #(
  parameter int unsigned PERIOD_W = 20,
  parameter logic [30:0] HYST     = 31'd0
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                step_in,
  input  logic signed [31:0]  sample_in,
  output logic [PERIOD_W-1:0] period_out,
  output logic [31:0]         phase_incr_out,
  output logic                valid_out,
  output logic                no_signal_out,
  output logic                busy_out
);

  localparam logic signed [31:0]  L_HYST_POS = $signed({1'b0, HYST});
  localparam logic signed [31:0]  L_HYST_NEG = -L_HYST_POS;
  localparam logic [PERIOD_W-1:0] L_CNT_MAX  = {PERIOD_W{1'b1}};
  localparam logic [32:0]         L_DIVIDEND = 33'h1_0000_0000;

  typedef enum logic {WAIT_FIRST, MEASURE} meas_state_t;
  typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_t;

  meas_state_t         r_meas_state;
  meas_state_t         w_meas_next;
  logic [PERIOD_W-1:0] r_cnt;
  logic [PERIOD_W-1:0] w_cnt_next;
  logic [PERIOD_W-1:0] w_cnt_inc;
  logic                r_armed;
  logic                w_below;
  logic                w_above;
  logic                w_edge;
  logic                w_req;
  logic                w_sat;

  logic                r_pend_vld;
  logic [PERIOD_W-1:0] r_pend_period;

  div_state_t          r_div_state;
  div_state_t          w_div_next;
  logic                w_load;
  logic                w_fin;
  logic [32:0]         r_dvd;
  logic [PERIOD_W-1:0] r_dvs;
  logic [PERIOD_W:0]   r_rem;
  logic [5:0]          r_bit;
  logic [PERIOD_W+1:0] w_rem_shift;
  logic [PERIOD_W+1:0] w_rem_sub;
  logic [PERIOD_W:0]   w_rem_next;
  logic                w_qbit;
  logic [31:0]         w_quo_final;

  assign w_below   = sample_in < L_HYST_NEG;
  assign w_above   = sample_in >= L_HYST_POS;
  assign w_edge    = step_in && r_armed && w_above;
  assign w_cnt_inc = r_cnt + 1'b1;

  always_comb begin
    w_meas_next = r_meas_state;
    w_cnt_next  = r_cnt;
    w_req       = 1'b0;
    w_sat       = 1'b0;
    if (step_in) begin
      case (r_meas_state)
        WAIT_FIRST: begin
          if (w_edge) begin
            w_cnt_next  = {{(PERIOD_W-1){1'b0}}, 1'b1};
            w_meas_next = MEASURE;
          end
        end
        MEASURE: begin
          if (w_edge) begin
            w_req      = 1'b1;
            w_cnt_next = {{(PERIOD_W-1){1'b0}}, 1'b1};
          end else if (w_cnt_inc == L_CNT_MAX) begin
            w_cnt_next  = L_CNT_MAX;
            w_sat       = 1'b1;
            w_meas_next = WAIT_FIRST;
          end else begin
            w_cnt_next = w_cnt_inc;
          end
        end
        default: w_meas_next = WAIT_FIRST;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_meas_state <= WAIT_FIRST;
      r_cnt        <= '0;
      r_armed      <= 1'b0;
    end else begin
      r_meas_state <= w_meas_next;
      r_cnt        <= w_cnt_next;
      if (step_in) begin
        if (w_edge)       r_armed <= 1'b0;
        else if (w_below) r_armed <= 1'b1;
      end
    end
  end

  // Restoring step: the borrow of the trial subtraction is the inverted quotient bit.
  assign w_rem_shift = {r_rem, r_dvd[32]};
  assign w_rem_sub   = w_rem_shift - {2'b00, r_dvs};
  assign w_qbit      = ~w_rem_sub[PERIOD_W+1];
  assign w_rem_next  = w_qbit ? w_rem_sub[PERIOD_W:0] : w_rem_shift[PERIOD_W:0];
  assign w_quo_final = {r_dvd[30:0], w_qbit};

  always_comb begin
    w_div_next = r_div_state;
    w_load     = 1'b0;
    w_fin      = 1'b0;
    case (r_div_state)
      DIV_IDLE: begin
        if (r_pend_vld) begin
          w_load     = 1'b1;
          w_div_next = DIV_RUN;
        end
      end
      DIV_RUN: begin
        if (r_bit == 6'd32) begin
          w_fin      = 1'b1;
          w_div_next = DIV_DONE;
        end
      end
      DIV_DONE: w_div_next = DIV_IDLE;
      default:  w_div_next = DIV_IDLE;
    endcase
  end

  assign busy_out = (r_div_state == DIV_RUN);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_div_state    <= DIV_IDLE;
      r_pend_vld     <= 1'b0;
      r_pend_period  <= '0;
      r_dvd          <= '0;
      r_dvs          <= '0;
      r_rem          <= '0;
      r_bit          <= '0;
      period_out     <= '0;
      phase_incr_out <= '0;
      valid_out      <= 1'b0;
      no_signal_out  <= 1'b1;
    end else begin
      r_div_state <= w_div_next;
      // A new edge wins over a same-cycle load so the freshest period is never lost.
      if (w_req) begin
        r_pend_vld    <= 1'b1;
        r_pend_period <= r_cnt;
      end else if (w_load) begin
        r_pend_vld <= 1'b0;
      end
      if (w_load) begin
        r_dvd <= L_DIVIDEND;
        r_dvs <= r_pend_period;
        r_rem <= '0;
        r_bit <= '0;
      end else if (r_div_state == DIV_RUN) begin
        r_dvd <= {r_dvd[31:0], w_qbit};
        r_rem <= w_rem_next;
        r_bit <= r_bit + 6'd1;
      end
      valid_out <= w_fin;
      if (w_fin) begin
        period_out     <= r_dvs;
        phase_incr_out <= w_quo_final;
      end
      if (w_sat)      no_signal_out <= 1'b1;
      else if (w_fin) no_signal_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_square_freq_detector.sv
// Scoreboard bench for square_freq_detector: three instances cover default, hysteresis and narrow-counter builds.
module tb_square_freq_detector;

  typedef struct {
    int          cyc;
    logic [19:0] p;
    logic [31:0] q;
  } exp_t;

  logic clk;
  logic rst;
  logic step_a, step_h, step_s;
  logic signed [31:0] sample;
  int cyc;
  int n_cmp;
  int n_bad;

  logic [19:0] period_a, period_h;
  logic [7:0]  period_s;
  logic [31:0] phase_a, phase_h, phase_s;
  logic valid_a, valid_h, valid_s;
  logic nosig_a, nosig_h, nosig_s;
  logic busy_a, busy_h, busy_s;

  exp_t sb_a[$];
  exp_t sb_h[$];
  exp_t sb_s[$];

  square_freq_detector #(.PERIOD_W(20), .HYST(31'd0)) dut_a (
    .clk_in(clk), .rst_in(rst), .step_in(step_a), .sample_in(sample),
    .period_out(period_a), .phase_incr_out(phase_a), .valid_out(valid_a),
    .no_signal_out(nosig_a), .busy_out(busy_a));

  square_freq_detector #(.PERIOD_W(20), .HYST(31'd1000)) dut_h (
    .clk_in(clk), .rst_in(rst), .step_in(step_h), .sample_in(sample),
    .period_out(period_h), .phase_incr_out(phase_h), .valid_out(valid_h),
    .no_signal_out(nosig_h), .busy_out(busy_h));

  square_freq_detector #(.PERIOD_W(8), .HYST(31'd0)) dut_s (
    .clk_in(clk), .rst_in(rst), .step_in(step_s), .sample_in(sample),
    .period_out(period_s), .phase_incr_out(phase_s), .valid_out(valid_s),
    .no_signal_out(nosig_s), .busy_out(busy_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int sel, input int c, input logic [19:0] p, input logic [31:0] q);
    exp_t e;
    e.cyc = c;
    e.p   = p;
    e.q   = q;
    case (sel)
      0:       sb_a.push_back(e);
      1:       sb_h.push_back(e);
      default: sb_s.push_back(e);
    endcase
  endtask

  task automatic mon(input int sel, input logic vld, input logic [19:0] p, input logic [31:0] q,
                     input logic ns, input logic bz);
    exp_t e;
    int   sz;
    if (vld) begin
      sz = (sel == 0) ? sb_a.size() : (sel == 1) ? sb_h.size() : sb_s.size();
      if (sz == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid dut%0d: got valid_out=1 expected no result (cycle %0d, period %0d)",
                 sel, cyc, p);
      end else begin
        case (sel)
          0:       e = sb_a.pop_front();
          1:       e = sb_h.pop_front();
          default: e = sb_s.pop_front();
        endcase
        chk("valid_cycle", 32'(cyc), 32'(e.cyc));
        chk("period_out", {12'd0, p}, {12'd0, e.p});
        chk("phase_incr_out", q, e.q);
        chk("no_signal_on_valid", {31'd0, ns}, 32'd0);
        chk("busy_on_valid", {31'd0, bz}, 32'd0);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, valid_a, period_a, phase_a, nosig_a, busy_a);
    mon(1, valid_h, period_h, phase_h, nosig_h, busy_h);
    mon(2, valid_s, {12'd0, period_s}, phase_s, nosig_s, busy_s);
  end

  task automatic quiet();
    @(posedge clk);
    #1;
    step_a = 1'b0;
    step_h = 1'b0;
    step_s = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    step_a = 1'b0;
    step_h = 1'b0;
    step_s = 1'b0;
    sample = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One strobe lasting 'gap' clocks: step high in the first, low in the rest.
  task automatic step_once(input int sel, input int val, input int gap, output int c);
    @(posedge clk);
    #1;
    sample = val;
    step_a = (sel == 0);
    step_h = (sel == 1);
    step_s = (sel == 2);
    c = cyc;
    for (int i = 1; i < gap; i++) begin
      @(posedge clk);
      #1;
      step_a = 1'b0;
      step_h = 1'b0;
      step_s = 1'b0;
    end
  endtask

  // Square oscillator: sign from phase MSB; a phase wrap is a rising edge, every edge after the first is a result.
  task automatic osc_run(input int sel, input logic [31:0] incr, input int amp, input int nsteps,
                         input int gap, input bit expect_res, input logic [19:0] ep, input logic [31:0] eq);
    logic [31:0] ph;
    logic [31:0] prev;
    int edges;
    int c;
    bit is_edge;
    ph = 32'd0;
    prev = 32'd0;
    edges = 0;
    for (int n = 0; n < nsteps; n++) begin
      is_edge = (n > 0) && (ph < prev);
      if (is_edge) edges++;
      step_once(sel, ph[31] ? -amp : amp, gap, c);
      if (is_edge && edges >= 2 && expect_res) push(sel, c + 35, ep, eq);
      prev = ph;
      ph = ph + incr;
    end
  endtask

  initial begin
    int c;
    int e1;
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    step_a = 1'b0;
    step_h = 1'b0;
    step_s = 1'b0;
    sample = '0;

    do_reset();
    chk("rst_period", {12'd0, period_a}, 32'd0);
    chk("rst_phase", phase_a, 32'd0);
    chk("rst_valid", {31'd0, valid_a}, 32'd0);
    chk("rst_no_signal", {31'd0, nosig_a}, 32'd1);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_no_signal_h", {31'd0, nosig_h}, 32'd1);
    chk("rst_no_signal_s", {31'd0, nosig_s}, 32'd1);

    for (int i = 0; i < 200; i++) step_once(0, 0, 1, c);
    quiet();
    repeat (40) @(posedge clk);
    #1;
    chk("idle_no_signal", {31'd0, nosig_a}, 32'd1);
    chk("idle_period", {12'd0, period_a}, 32'd0);
    chk("idle_phase", phase_a, 32'd0);
    chk("idle_busy", {31'd0, busy_a}, 32'd0);

    do_reset();
    osc_run(0, 32'h1000_0000, 20000, 81, 4, 1'b1, 20'd16, 32'd268435456);
    repeat (40) @(posedge clk);
    #1;
    chk("p16_drained", sb_a.size(), 32'd0);
    chk("p16_no_signal", {31'd0, nosig_a}, 32'd0);
    chk("p16_period_hold", {12'd0, period_a}, 32'd16);

    do_reset();
    osc_run(0, 32'd171798691, 20000, 102, 2, 1'b1, 20'd25, 32'd171798691);
    repeat (40) @(posedge clk);
    #1;
    chk("p25_drained", sb_a.size(), 32'd0);
    chk("p25_phase_hold", phase_a, 32'd171798691);

    do_reset();
    e1 = 0;
    for (int j = 0; j < 37; j++) begin
      step_once(0, -1, 1, c);
      step_once(0, 1, 1, c);
      if (j == 1) begin
        e1 = c;
        push(0, e1 + 35, 20'd2, 32'd2147483648);
        push(0, e1 + 70, 20'd2, 32'd2147483648);
        push(0, e1 + 105, 20'd2, 32'd2147483648);
      end
    end
    quiet();
    repeat (120) @(posedge clk);
    #1;
    chk("pmin_drained", sb_a.size(), 32'd0);

    do_reset();
    osc_run(1, 32'd107374182, 500, 200, 1, 1'b0, 20'd0, 32'd0);
    quiet();
    repeat (40) @(posedge clk);
    #1;
    chk("hyst_small_no_signal", {31'd0, nosig_h}, 32'd1);
    chk("hyst_small_period", {12'd0, period_h}, 32'd0);
    osc_run(1, 32'd107374182, 5000, 122, 1, 1'b1, 20'd40, 32'd107374182);
    quiet();
    repeat (40) @(posedge clk);
    #1;
    chk("hyst_big_drained", sb_h.size(), 32'd0);
    chk("hyst_big_no_signal", {31'd0, nosig_h}, 32'd0);

    do_reset();
    osc_run(2, 32'h1000_0000, 20000, 49, 4, 1'b1, 20'd16, 32'd268435456);
    for (int i = 0; i < 253; i++) step_once(2, 100, 1, c);
    quiet();
    chk("sat_253_no_signal", {31'd0, nosig_s}, 32'd0);
    chk("sat_253_drained", sb_s.size(), 32'd0);
    step_once(2, 100, 1, c);
    quiet();
    chk("sat_254_no_signal", {31'd0, nosig_s}, 32'd1);
    chk("sat_period_hold", {24'd0, period_s}, 32'd16);
    chk("sat_phase_hold", phase_s, 32'd268435456);

    osc_run(2, 32'h1000_0000, 20000, 49, 4, 1'b1, 20'd16, 32'd268435456);
    repeat (10) @(posedge clk);
    #1;
    chk("abort_busy", {31'd0, busy_s}, 32'd1);
    chk("abort_pending_result", sb_s.size(), 32'd1);
    if (sb_s.size() > 0) void'(sb_s.pop_back());
    do_reset();
    chk("abort_period", {24'd0, period_s}, 32'd0);
    chk("abort_phase", phase_s, 32'd0);
    chk("abort_valid", {31'd0, valid_s}, 32'd0);
    chk("abort_no_signal", {31'd0, nosig_s}, 32'd1);
    chk("abort_busy_clear", {31'd0, busy_s}, 32'd0);
    repeat (60) @(posedge clk);
    #1;
    chk("abort_no_result", sb_s.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/square_freq_detector.md
Name: square_freq_detector

Overview:
Inverse of the square oscillator. Watches a signed 32-bit oscillator or audio sample stream qualified by step_in, and measures the number of samples between rising zero-crossings (with hysteresis). It then recovers the equivalent 32-bit phase increment, floor(2^32 / period), using a serial restoring divider. It sits downstream of the oscillator bank and is used for tuning display and closed-loop pitch tests.

Parameters:
PERIOD_W, 20, width of the period counter and period_out; maximum measurable period is 2^PERIOD_W-1 samples.
HYST, 0, hysteresis threshold, unsigned 31-bit magnitude.

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous reset, active-high
step_in  input  1  sample strobe; sample_in is valid only on cycles where step_in=1
sample_in  input  32  signed sample
period_out  output  PERIOD_W  last measured period in samples
phase_incr_out  output  32  floor(2^32 / period_out)
valid_out  output  1  one-cycle pulse when period_out and phase_incr_out update
no_signal_out  output  1  high while no rising edge has been seen within the maximum period
busy_out  output  1  divider running

Behaviour:
- One clock domain. Reset is synchronous and active-high on rst_in.
- Reset values: period_out=0, phase_incr_out=0, valid_out=0, no_signal_out=1, busy_out=0. Reset also clears the counter, the armed flag, the pending register and the FSM.
- Reset during a division aborts it; no valid_out is produced.
- Edge detection is evaluated only on step_in=1:
  - armed is set when sample_in < -HYST (signed compare).
  - A rising edge occurs when armed=1 and sample_in >= HYST; armed clears on the same step.
  - With HYST=0: sample < 0 arms; sample >= 0 triggers.
- Measurement FSM, states WAIT_FIRST and MEASURE:
  - WAIT_FIRST is the reset state. On an edge: cnt=1, go to MEASURE, no measurement produced.
  - MEASURE, on each step_in without an edge: cnt saturates-increments. If cnt reaches 2^PERIOD_W-1: no_signal_out=1, go to WAIT_FIRST, and period_out/phase_incr_out hold their old values.
  - MEASURE, on a step_in with an edge: latch period=cnt into the divider request, then cnt=1 (the edge sample counts as sample 1 of the next period).
  - no_signal_out clears on the first completed measurement.
- Period value: the number of step_in strobes from one edge sample to the next, inclusive of the new edge and exclusive of the old one. The minimum possible value is 2.
- Divider FSM, states DIV_IDLE, DIV_RUN, DIV_DONE:
  - DIV_IDLE: when a request is present, load dividend 2^32 (33-bit) and divisor = period, go to DIV_RUN, busy_out=1.
  - DIV_RUN: one quotient bit per clock, MSB first, 33 cycles. The remainder register is PERIOD_W+1 bits.
  - DIV_DONE (1 cycle): period_out <= divisor and phase_incr_out <= quotient[31:0], both updating in the same cycle. valid_out=1 for that cycle only, busy_out=0, return to DIV_IDLE.
  - Quotient bit 32 is always 0 for period >= 2 and is discarded.
- Latency: valid_out asserts 35 clocks after the edge-detecting step_in cycle (1 latch/load + 33 iterations + 1 done).
- Edge during a busy divider: the new period goes into a one-deep pending register. A later edge overwrites it (last wins). It starts immediately after DIV_DONE. Outputs never show a stale period paired with a new quotient.
- step_in=0 cycles change nothing in the counter or edge logic. The divider advances every clock regardless of step_in.
- A simultaneous edge and saturation cannot happen: the edge takes priority.

Test Plan:
- Reset then idle: hold rst_in 3 cycles, apply 200 zero samples (0 >= 0 but never armed) -> no_signal_out=1, valid_out never asserts, outputs 0.
- Oscillator with PHASE_INCR=2^28 (0x10000000), step_in every 4th clock -> after the second edge: period_out=16, phase_incr_out=268435456, valid_out pulses once per 16 samples; no_signal_out drops on the first valid.
- PHASE_INCR=171798691 (2^32/25) -> period_out=25 and phase_incr_out=171798691 on every measurement.
- Minimum period: samples alternate -1, +1 with step_in=1 every clock -> period=2 arrives every 2 clocks. Pending register overwritten; each valid_out shows period_out=2 and phase_incr_out=2147483648, spaced 35 clocks apart.
- Hysteresis HYST=1000 with a square wave of ±500 plus edges -> no edges detected, no_signal_out stays 1. Amplitude ±5000 at period 40 -> period_out=40, phase_incr_out=107374182.
- PERIOD_W=8, signal stops after a valid measurement -> no_signal_out=1 after 254 further steps, outputs hold. Resume -> first edge gives no output; second edge produces a valid measurement. Assert rst_in mid-division -> no valid_out, all outputs return to reset values.
